// File: rtl/ss_display_arbiter.sv
// Round-robin owner of the two 4-digit seven-segment banks with a minimum dwell per owner.
// Define SS_DISPLAY_LZ_BLANK_EN to blank the anodes of leading-zero nibbles.
module ss_display_arbiter #(
    parameter int NREQ         = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DWELL_FRAMES = 256
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req,
    input  logic [32*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]        grant,
    output logic [3:0]             digit0,
    output logic [3:0]             digit1,
    output logic [3:0]             D0_AN,
    output logic [3:0]             D1_AN
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);
    localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    // First asserted request searching upward from prev+1; prev itself is tried last.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] prev);
        logic [IW-1:0] pick;
        int            idx;
        pick = prev;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(prev) + i) % NREQ;
            if (r[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [1:0]      sel_q, sel_d;
    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [31:0]     snap_q;
    logic [DW-1:0]   dwell_q;
    logic [IW-1:0]   last_q;

    logic            tick_s, frame_end_s, switch_s, other_req_s;
    logic [IW-1:0]   pick_s;
    logic [31:0]     pick_data_s, owner_data_s;

    // Prescaler, digit select and owner-switch decision.
    always_comb begin
        tick_s       = (pcnt_q == PCNT_MAX);
        pcnt_d       = tick_s ? {PW{1'b0}} : pcnt_q + PW'(1);
        sel_d        = tick_s ? sel_q + 2'd1 : sel_q;
        frame_end_s  = tick_s && (sel_q == 2'd3);
        pick_s       = rr_pick(req, last_q);
        pick_data_s  = req_data[32*int'(pick_s) +: 32];
        owner_data_s = req_data[32*int'(last_q) +: 32];
        other_req_s  = |(req & ~grant_q);
        switch_s     = !req[last_q] || ((dwell_q == DWELL_MAX) && other_req_s);
    end

    // Ownership FSM; last_q doubles as the current owner index while in ST_OWN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt_q  <= {PW{1'b0}};
            sel_q   <= 2'd0;
            state_q <= ST_IDLE;
            grant_q <= {NREQ{1'b0}};
            snap_q  <= 32'h0000_0000;
            dwell_q <= {DW{1'b0}};
            last_q  <= LAST_RST;
        end else begin
            pcnt_q <= pcnt_d;
            sel_q  <= sel_d;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_OWN;
                        grant_q <= NREQ'(1) << pick_s;
                        snap_q  <= pick_data_s;
                        dwell_q <= {DW{1'b0}};
                        last_q  <= pick_s;
                    end else begin
                        grant_q <= {NREQ{1'b0}};
                    end
                end
                ST_OWN: begin
                    if (frame_end_s && switch_s && (|req)) begin
                        grant_q <= NREQ'(1) << pick_s;
                        snap_q  <= pick_data_s;
                        dwell_q <= {DW{1'b0}};
                        last_q  <= pick_s;
                    end else if (frame_end_s && switch_s) begin
                        state_q <= ST_IDLE;
                        grant_q <= {NREQ{1'b0}};
                        dwell_q <= {DW{1'b0}};
                    end else if (frame_end_s) begin
                        // Reload even if the owner has dropped its request.
                        snap_q <= owner_data_s;
                        if (dwell_q != DWELL_MAX) begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= {NREQ{1'b0}};
                end
            endcase
        end
    end

`ifdef SS_DISPLAY_LZ_BLANK_EN
    logic [2:0] lead_s;

    // Index (bank,sel) of the most significant nonzero nibble; 7 keeps one digit lit for zero.
    always_comb begin
        lead_s = 3'd7;
        for (int n = 7; n >= 0; n--) begin
            if (snap_q[31-4*n -: 4] != 4'h0) lead_s = 3'(n);
        end
    end
`endif

    // Display drive derived from registers only.
    always_comb begin
        grant  = grant_q;
        digit0 = 4'h0;
        digit1 = 4'h0;
        D0_AN  = 4'hF;
        D1_AN  = 4'hF;
        if (state_q == ST_OWN) begin
            digit0 = snap_q[31-4*int'(sel_q) -: 4];
            digit1 = snap_q[15-4*int'(sel_q) -: 4];
`ifdef SS_DISPLAY_LZ_BLANK_EN
            D0_AN[sel_q] = ({1'b0, sel_q} < lead_s) ? 1'b1 : 1'b0;
            D1_AN[sel_q] = ({1'b1, sel_q} < lead_s) ? 1'b1 : 1'b0;
`else
            D0_AN[sel_q] = 1'b0;
            D1_AN[sel_q] = 1'b0;
`endif
        end else begin
            digit0 = 4'h0;
            digit1 = 4'h0;
        end
    end

endmodule

// File: doc/ss_display_arbiter.md
# ss_display_arbiter

Time-shares the board's two 4-digit seven-segment banks between up to NREQ requesters, such as CPU debug word, PC, halt code and cache stats. Each requester presents a request and a 32-bit value. The block grants one owner at a time in round-robin order, with a minimum dwell per owner, and scans that owner's value across both banks. Its outputs feed the existing hex-to-segment decoders and the anode pins in the FPGA top level.

## Interface
- NREQ, 4: number of requesters, 2..8.
- SCAN_DIV, 100000: CLK cycles per digit slot; at least 2.
- DWELL_FRAMES, 256: full scan frames an owner keeps the display before it can be rotated away; at least 1.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester display request, level-sensitive.
- req_data  input  32*NREQ  requester i value at bits [32*i+31 : 32*i].
- grant  output  NREQ  one-hot current owner, registered; all zeros when idle.
- digit0  output  4  nibble for bank 0 decoder.
- digit1  output  4  nibble for bank 1 decoder.
- D0_AN  output  4  bank 0 anodes, active-low.
- D1_AN  output  4  bank 1 anodes, active-low.

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. `tick` = (pcnt == SCAN_DIV-1).
- 2-bit sel increments on tick and wraps 3 to 0.
- `frame_end` = tick && sel == 3. One frame is 4*SCAN_DIV cycles.
- Display mapping:
  - digit0 = snap[31-4*sel -: 4]
  - digit1 = snap[15-4*sel -: 4]
  - D0_AN[sel] = D1_AN[sel] = 0; all other anodes are 1.
- snap is a 32-bit snapshot register. req_data is never displayed live, so there is no tearing within a frame.
- States:
  - IDLE: grant=0, all anodes 1, digits 0.
  - OWN: grant one-hot, display active.
- IDLE to OWN: on any cycle where req != 0.
  - owner = first asserted req searching upward from (last+1) mod NREQ.
  - snap loads that requester's data on the same edge; dwell counter cleared.
- OWN, at each frame_end:
  - snap reloads from the current owner's req_data, whether or not the owner still requests.
  - dwell increments, saturating at DWELL_FRAMES-1.
- OWN, owner switch at frame_end, taken when either condition holds:
  - owner's req is low, or
  - dwell == DWELL_FRAMES-1 and another req is high.
- Switch target: round-robin search starting at owner+1 (excluding the owner unless it is the only requester). Snap loads the new owner's data, dwell clears, last = new owner.
  - No requester high: go to IDLE, grant=0.
- Owner dropping req mid-frame has no effect until frame_end; its last snapshot stays displayed.
- Sole requester past its dwell keeps ownership; dwell stays saturated.
- Simultaneous owner drop and dwell expiry resolve identically: one round-robin pick.
- pcnt and sel are free-running in all states; entering OWN does not reset them.

## Timing
- Reset values (asynchronous, immediate):
  - pcnt=0, sel=0, state IDLE, grant=0, snap=0, dwell=0, last=NREQ-1 (requester 0 wins first).
  - D0_AN=D1_AN=4'b1111, digit0=digit1=0.
- grant asserts on the first edge where req != 0 is sampled in IDLE (1-cycle latency). Anodes and digits reflect snap combinationally in the same cycle.
- sel, grant and snap change only on tick or frame_end edges, or on the IDLE-to-OWN edge.
- Anode and digit outputs derive from registers only; there is no combinational path from req or req_data.
- RST asserted mid-frame or mid-dwell: all state clears at once. After release, the first grant goes to requester 0 if requesting.

## Configuration
- SS_DISPLAY_LZ_BLANK_EN: leading-zero blanking.
- Defined:
  - For the 8 nibbles of snap (sel 0..3 on bank 0, then sel 0..3 on bank 1), every nibble more significant than the highest nonzero nibble has its anode held at 1.
  - snap == 0 lights only bank 1, sel 3, showing 0.
  - Digit values are unchanged.
- Undefined: all 8 digits always lit in OWN.

## Test plan
- Bench parameters: SCAN_DIV=4, DWELL_FRAMES=2, NREQ=4.
- Reset then req=0001, data0=32'hDEADBEEF -> grant=0001 one cycle later. Anode pattern per sel step: D0_AN 1110,1101,1011,0111. Digits cycle D/E/A/D on bank 0 and B/E/E/F on bank 1, 4 cycles each.
- req=0101 held -> grant 0001 for 2 frames (32 cycles), then 0100 at frame_end for 2 frames, then back to 0001. Round-robin never skips requester 2.
- Owner 0 changes data0 to 32'h12345678 mid-frame -> display still shows DEADBEEF until frame_end, then 12345678.
- Owner drops req at dwell 0 with req=0000 -> grant holds to frame_end, then 0000 and all anodes 1111. Raising req=1000 -> grant=1000 next cycle.
- RST pulsed for 1 cycle while owner=2, sel=2 -> grant=0, AN=1111, sel=0 at once. With req=0111 after release -> grant=0001.
- With SS_DISPLAY_LZ_BLANK_EN defined, data=32'h000000A5 -> only bank 1 sel 2 and 3 anodes go low, showing A and 5. data=0 -> only D1_AN[3] low, showing 0.
